// File: rtl/counter8b_sched_if.sv
// Request/grant bundle for the shared 8-bit counter scheduler.
// The master modport drives requests; the slave modport is the scheduler side.
interface counter8b_sched_if;
  logic       req0;
  logic [7:0] tgt0;
  logic       req1;
  logic [7:0] tgt1;
  logic       hold;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic       busy;
  logic       dir;
  logic [7:0] count;

  modport master (
    output req0, tgt0, req1, tgt1, hold,
    input  gnt0, gnt1, done0, done1, busy, dir, count
  );

  modport slave (
    input  req0, tgt0, req1, tgt1, hold,
    output gnt0, gnt1, done0, done1, busy, dir, count
  );
endinterface

// File: rtl/counter8b_sched.sv
// Two requesters share one counter. Round-robin arbitration picks an owner.
// The owner's latched target is then walked toward one step per cycle, with hold and abort.
module counter8b_sched (
  input  logic              clk,
  input  logic              reset,
  counter8b_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] tgt_q, tgt_d;
  logic       dir_q, dir_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;

  logic       winner;
  logic       owner_req;

  // On a tie the requester that did not win last time takes the grant.
  assign winner    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
  assign owner_req = owner_q ? bus.req1 : bus.req0;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_d = winner;
          last_d  = winner;
          tgt_d   = winner ? bus.tgt1 : bus.tgt0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Losing the owner's request beats both hold and completion.
        if (!owner_req) begin
          state_d = IDLE;
        end else if (!bus.hold) begin
          if (count_q < tgt_q) begin
            count_d = count_q + 8'd1;
            dir_d   = 1'b1;
          end else if (count_q > tgt_q) begin
            count_d = count_q - 8'd1;
            dir_d   = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 8'd0;
      tgt_q   <= 8'd0;
      dir_q   <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Outputs decode straight from flops so an async reset clears them at once.
  assign bus.busy  = (state_q != IDLE);
  assign bus.gnt0  = bus.busy && !owner_q;
  assign bus.gnt1  = bus.busy &&  owner_q;
  assign bus.done0 = (state_q == DONE) && !owner_q;
  assign bus.done1 = (state_q == DONE) &&  owner_q;
  assign bus.dir   = dir_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_counter8b_sched.sv
// Directed bench for counter8b_sched: grants, stepping, hold, abort, async reset and range ends.
module tb_counter8b_sched;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  counter8b_sched_if bus ();

  counter8b_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.req0 = 1'b0;
    bus.tgt0 = 8'd0;
    bus.req1 = 1'b0;
    bus.tgt1 = 8'd0;
    bus.hold = 1'b0;
    reset    = 1'b1;
    #12;
    check("rst_count", bus.count, 0);
    check("rst_busy",  bus.busy,  0);
    check("rst_gnt0",  bus.gnt0,  0);
    check("rst_gnt1",  bus.gnt1,  0);
    check("rst_dir",   bus.dir,   0);
    check("rst_done",  {bus.done0, bus.done1}, 0);
    reset = 1'b0;
    $display("reset: count=%0d busy=%0d", bus.count, bus.busy);

    // Up-count 0 -> 5 by requester 0.
    bus.req0 = 1'b1;
    bus.tgt0 = 8'd5;
    tick();
    check("up_gnt0", bus.gnt0, 1);
    check("up_busy", bus.busy, 1);
    check("up_cnt0", bus.count, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("up_count", bus.count, i);
      check("up_dir",   bus.dir, 1);
      check("up_nodone", bus.done0, 0);
    end
    tick();
    check("up_done0", bus.done0, 1);
    check("up_done1", bus.done1, 0);
    check("up_hold5", bus.count, 5);
    bus.req0 = 1'b0;
    tick();
    check("up_done_drop", bus.done0, 0);
    check("up_gnt_drop",  bus.gnt0, 0);
    check("up_idle",      bus.busy, 0);
    $display("up-count: count=%0d", bus.count);

    // Tie with last winner 0: requester 1 wins, counts 5 -> 2; requester 0 stays pending.
    bus.req0 = 1'b1;
    bus.tgt0 = 8'd5;
    bus.req1 = 1'b1;
    bus.tgt1 = 8'd2;
    tick();
    check("tie_gnt1", bus.gnt1, 1);
    check("tie_gnt0", bus.gnt0, 0);
    for (int i = 4; i >= 2; i--) begin
      tick();
      check("dn_count", bus.count, i);
      check("dn_dir",   bus.dir, 0);
    end
    tick();
    check("dn_done1", bus.done1, 1);
    check("dn_done0", bus.done0, 0);
    check("dn_gnt0_out", bus.gnt0, 0);
    bus.req1 = 1'b0;
    tick();
    check("dn_idle", bus.busy, 0);
    check("dn_gnt1_drop", bus.gnt1, 0);
    check("dn_gnt0_wait", bus.gnt0, 0);
    tick();
    check("pend_gnt0", bus.gnt0, 1);
    for (int i = 3; i <= 5; i++) begin
      tick();
      check("pend_count", bus.count, i);
      check("pend_dir",   bus.dir, 1);
    end
    tick();
    check("pend_done0", bus.done0, 1);
    bus.req0 = 1'b0;
    tick();
    check("pend_idle", bus.busy, 0);
    $display("tie/down: count=%0d", bus.count);

    // Zero distance: target equals count.
    bus.req0 = 1'b1;
    bus.tgt0 = 8'd5;
    tick();
    check("zero_gnt0", bus.gnt0, 1);
    tick();
    check("zero_done0", bus.done0, 1);
    check("zero_count", bus.count, 5);
    check("zero_dir",   bus.dir, 1);
    bus.req0 = 1'b0;
    tick();
    check("zero_idle", bus.busy, 0);
    $display("zero-distance: count=%0d", bus.count);

    // Hold for three cycles during a 5 -> 8 run.
    bus.req1 = 1'b1;
    bus.tgt1 = 8'd8;
    tick();
    check("hold_gnt1", bus.gnt1, 1);
    tick();
    check("hold_c6", bus.count, 6);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_frozen", bus.count, 6);
      check("hold_busy",   bus.busy, 1);
    end
    bus.hold = 1'b0;
    tick();
    check("hold_c7", bus.count, 7);
    tick();
    check("hold_c8", bus.count, 8);
    check("hold_nodone", bus.done1, 0);
    tick();
    check("hold_done1", bus.done1, 1);
    bus.req1 = 1'b0;
    tick();
    check("hold_idle", bus.busy, 0);
    $display("hold: count=%0d", bus.count);

    // Target change after grant is ignored; abort at count 3 beats completion.
    bus.req0 = 1'b1;
    bus.tgt0 = 8'd3;
    tick();
    check("ab_gnt0", bus.gnt0, 1);
    bus.tgt0 = 8'd200;
    for (int i = 7; i >= 3; i--) begin
      tick();
      check("ab_count", bus.count, i);
    end
    bus.req0 = 1'b0;
    tick();
    check("ab_gnt0_drop", bus.gnt0, 0);
    check("ab_nodone",    bus.done0, 0);
    check("ab_idle",      bus.busy, 0);
    check("ab_count3",    bus.count, 3);
    tick();
    check("ab_still_nodone", bus.done0, 0);
    $display("abort: count=%0d", bus.count);

    // Async reset between edges mid-run.
    bus.req1 = 1'b1;
    bus.tgt1 = 8'd10;
    tick();
    tick();
    tick();
    check("ar_count5", bus.count, 5);
    #2;
    reset = 1'b1;
    #1;
    check("ar_count", bus.count, 0);
    check("ar_gnt1",  bus.gnt1, 0);
    check("ar_busy",  bus.busy, 0);
    check("ar_dir",   bus.dir, 0);
    reset = 1'b0;
    tick();
    check("ar_regrant", bus.gnt1, 1);
    bus.req1 = 1'b0;
    tick();
    check("ar_abort_idle", bus.busy, 0);
    check("ar_abort_cnt",  bus.count, 0);
    $display("async reset: count=%0d", bus.count);

    // Range: 0 -> 255 and 255 -> 0 without wrap.
    bus.req0 = 1'b1;
    bus.tgt0 = 8'd255;
    tick();
    check("rng_up_gnt", bus.gnt0, 1);
    for (int i = 1; i <= 255; i++) begin
      tick();
      check("rng_up_count", bus.count, i);
    end
    tick();
    check("rng_up_done",  bus.done0, 1);
    check("rng_up_nowrap", bus.count, 255);
    bus.req0 = 1'b0;
    tick();
    bus.req1 = 1'b1;
    bus.tgt1 = 8'd0;
    tick();
    check("rng_dn_gnt", bus.gnt1, 1);
    for (int i = 254; i >= 0; i--) begin
      tick();
      check("rng_dn_count", bus.count, i);
    end
    tick();
    check("rng_dn_done",  bus.done1, 1);
    check("rng_dn_nowrap", bus.count, 0);
    check("rng_dn_dir",   bus.dir, 0);
    bus.req1 = 1'b0;
    tick();
    check("rng_dn_idle", bus.busy, 0);
    $display("range: count=%0d", bus.count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/counter8b_sched.md
COUNTER8B_SCHED -- requirements
Module: counter8b_sched

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: req0  input  1  requester 0 asks to move the counter.
REQ-004 SHALL have port: tgt0  input  8  requester 0 target value.
REQ-005 SHALL have port: req1  input  1  requester 1 asks to move the counter.
REQ-006 SHALL have port: tgt1  input  8  requester 1 target value.
REQ-007 SHALL have port: hold  input  1  freezes stepping while high.
REQ-008 SHALL have port: gnt0 / gnt1  output  1 each  requester owns the counter.
REQ-009 SHALL have port: done0 / done1  output  1 each  one-cycle completion pulse to the owner.
REQ-010 SHALL have port: busy  output  1  state is not IDLE.
REQ-011 SHALL have port: dir  output  1  direction of the last step: 1 = up, 0 = down.
REQ-012 SHALL have port: count  output  8  shared counter value.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE; busy SHALL equal (state != IDLE).
REQ-014 IDLE SHALL arbitrate at each posedge clk where req0 or req1 is high, then on that same edge:
- set gnt of the winner;
- latch the winner's target into an internal 8-bit tgt_q;
- go to RUN.
REQ-015 Arbitration SHALL be round-robin:
- single requester wins;
- if both request, the winner is the requester that did not win last;
- last_winner resets to 1, so req0 wins the first tie.
REQ-016 tgt0/tgt1 changes after the grant edge SHALL be ignored until the next grant.
REQ-017 In RUN with hold=0, each edge SHALL do exactly one of:
- count < tgt_q: count+1, dir<=1;
- count > tgt_q: count-1, dir<=0;
- count == tgt_q: count and dir unchanged, go to DONE, assert the owner's done.
REQ-018 In RUN with hold=1, count, dir and state SHALL be unchanged.
REQ-019 The counter SHALL never wrap: stepping is always toward tgt_q within 0..255, and all arithmetic is 8-bit.
REQ-020 DONE SHALL last exactly one cycle; on the next edge:
- done drops;
- gnt drops;
- go to IDLE.
REQ-021 Earliest next grant SHALL be the edge after the return to IDLE, so there is at least one idle cycle between ownerships.
REQ-022 Latency SHALL be as follows:
- grant at edge E0;
- |tgt_q-count| steps on E1..Ek;
- done high after E(k+1), plus hold cycles;
- gnt low after E(k+2).
REQ-023 If count == tgt_q at grant, RUN SHALL last one cycle (k=0) with no step.
REQ-024 Abort: if the owner's req is low at an edge in RUN, the FSM SHALL go to IDLE and drop gnt with no done pulse; count keeps its current value.
REQ-025 Abort SHALL take priority over the count == tgt_q completion on the same edge.
REQ-026 The non-owner's req SHALL be ignored outside IDLE and SHALL stay pending without being lost.
REQ-027 done0 and done1 SHALL never be high together; gnt0 and gnt1 SHALL never be high together.
REQ-028 last_winner SHALL update on every grant edge.

Reset
REQ-029 reset high SHALL immediately, without a clock edge, force all of the following: state=IDLE, count=0, dir=0, gnt0=gnt1=0, done0=done1=0, busy=0, tgt_q=0, last_winner=1.
REQ-030 Reset mid-RUN SHALL abandon the operation with no done pulse; the first grant SHALL be possible on the first edge after reset falls.

Verification
REQ-031 Up-count: reset, then req0=1 with tgt0=5 -> gnt0 after E0; count 1..5 on E1..E5; done0 high one cycle after E6; gnt0 low after E7; dir=1.
REQ-032 Down-count with tie: count=5, req0 and req1 both high with tgt1=2 and last winner 0 -> gnt1; count 4,3,2; dir=0; done1 one cycle; then req0 is granted after one idle cycle.
REQ-033 Hold and zero-distance: tgt0 equals count -> done0 after E1; hold=1 for 3 cycles mid-run -> count frozen and completion delayed by exactly 3 cycles.
REQ-034 Abort and target change: tgt0 changed after grant -> original target reached; req0 dropped mid-run at count=3 -> gnt0 low, no done0, count stays 3.
REQ-035 Async reset: reset pulsed between edges mid-run -> all outputs 0 before the next edge; range edges: tgt=255 from 0 -> 255 steps, no wrap; tgt=0 from 255 -> reaches 0, no wrap.
